// File: rtl/pipe_ctrl_if.sv
// Stage-facing signal bundle of the pipeline controller: stall requests and
// exception reports in, stall vector and flush/redirect out.
interface pipe_ctrl_if;
  logic        stallreq_if;
  logic        stallreq_id;
  logic        stallreq_ex;
  logic        stallreq_mem;
  logic        excp_valid;
  logic [31:0] excp_type;
  logic [31:0] cp0_epc;
  logic [5:0]  stall;
  logic        flush;
  logic [31:0] new_pc;

  modport master (
    output stallreq_if, stallreq_id, stallreq_ex, stallreq_mem,
    output excp_valid, excp_type, cp0_epc,
    input  stall, flush, new_pc
  );

  modport slave (
    input  stallreq_if, stallreq_id, stallreq_ex, stallreq_mem,
    input  excp_valid, excp_type, cp0_epc,
    output stall, flush, new_pc
  );
endinterface

// File: rtl/pipe_ctrl.sv
// Pipeline controller: stall merge, exception/ERET flush sequencing, stall counter.
// Optional STALL_WATCHDOG_EN adds a consecutive-stall watchdog that forces a flush.
module pipe_ctrl #(
  parameter logic [31:0] EXC_VECTOR = 32'hBFC00380,
  parameter logic [31:0] ERET_CODE  = 32'h0000000E,
  parameter int unsigned WDOG_LIMIT = 1024
) (
  input  logic        clk,
  input  logic        rst,
  pipe_ctrl_if.slave  pif,
  output logic [1:0]  ctrl_state,
  output logic [31:0] stall_cycles,
  output logic        wdog_trip
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PEND    = 2'd1,
    RECOVER = 2'd2
  } state_t;

  state_t      state;
  logic [31:0] lat_type;
  logic [31:0] lat_epc;
  logic [5:0]  prio_stall;
  logic        wdog_hit;

  assign ctrl_state = state;

  always_comb begin
    prio_stall = 6'b000000;
    if (pif.stallreq_mem)     prio_stall = 6'b011111;
    else if (pif.stallreq_ex) prio_stall = 6'b001111;
    else if (pif.stallreq_id) prio_stall = 6'b000111;
    else if (pif.stallreq_if) prio_stall = 6'b000011;
  end

  // Outputs are combinational so stage registers react in the same cycle.
  always_comb begin
    pif.stall  = '0;
    pif.flush  = 1'b0;
    pif.new_pc = '0;
    if (!rst) begin
      unique case (state)
        IDLE: begin
          if (wdog_hit) begin
            pif.flush  = 1'b1;
            pif.new_pc = EXC_VECTOR;
          end else if (pif.excp_valid && !pif.stallreq_mem) begin
            pif.flush  = 1'b1;
            pif.new_pc = (pif.excp_type == ERET_CODE) ? pif.cp0_epc : EXC_VECTOR;
          end else begin
            pif.stall = prio_stall;
          end
        end
        PEND: begin
          if (pif.stallreq_mem) begin
            pif.stall = 6'b011111;
          end else begin
            pif.flush  = 1'b1;
            pif.new_pc = (wdog_hit || lat_type != ERET_CODE) ? EXC_VECTOR : lat_epc;
          end
        end
        RECOVER: pif.stall = prio_stall;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      lat_type     <= '0;
      lat_epc      <= '0;
      stall_cycles <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (pif.flush) begin
            state <= RECOVER;
          end else if (pif.excp_valid) begin
            lat_type <= pif.excp_type;
            lat_epc  <= pif.cp0_epc;
            state    <= PEND;
          end
        end
        PEND:    if (!pif.stallreq_mem) state <= RECOVER;
        RECOVER: state <= IDLE;
        default: state <= IDLE;
      endcase
      if (pif.stall[0] && stall_cycles != '1)
        stall_cycles <= stall_cycles + 32'd1;
    end
  end

`ifdef STALL_WATCHDOG_EN
  logic [15:0] wdog_cnt;

  // The count survives a PEND wait (stall stays asserted), so the PEND exit
  // still sees the hit and redirects to the exception vector.
  assign wdog_hit = (32'(wdog_cnt) >= WDOG_LIMIT);

  always_ff @(posedge clk) begin
    if (rst) begin
      wdog_cnt  <= '0;
      wdog_trip <= 1'b0;
    end else begin
      if (pif.flush || pif.stall == 6'b000000)
        wdog_cnt <= '0;
      else if (wdog_cnt != '1)
        wdog_cnt <= wdog_cnt + 16'd1;
      if (pif.flush && wdog_hit)
        wdog_trip <= 1'b1;
    end
  end
`else
  assign wdog_hit  = 1'b0;
  assign wdog_trip = 1'b0;
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed self-checking bench for pipe_ctrl with hand-computed expectations.
module tb_pipe_ctrl;
  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  ctrl_state;
  logic [31:0] stall_cycles;
  logic        wdog_trip;
  int          checks = 0;
  int          failures = 0;
  int          found_at;

  localparam logic [31:0] EXC = 32'hBFC00380;

  pipe_ctrl_if pif ();

  pipe_ctrl #(.WDOG_LIMIT(8)) dut (
    .clk          (clk),
    .rst          (rst),
    .pif          (pif.slave),
    .ctrl_state   (ctrl_state),
    .stall_cycles (stall_cycles),
    .wdog_trip    (wdog_trip)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_in();
    pif.stallreq_if  = 1'b0;
    pif.stallreq_id  = 1'b0;
    pif.stallreq_ex  = 1'b0;
    pif.stallreq_mem = 1'b0;
    pif.excp_valid   = 1'b0;
    pif.excp_type    = '0;
    pif.cp0_epc      = '0;
  endtask

  initial begin
    clear_in();
    rst = 1'b1;
    pif.stallreq_id = 1'b1;
    pif.excp_valid  = 1'b1;
    #2;
    chk("rst_stall", 32'(pif.stall), 32'h0);
    chk("rst_flush", 32'(pif.flush), 32'h0);
    chk("rst_newpc", pif.new_pc, 32'h0);
    tick(); tick();
    chk("rst_state", 32'(ctrl_state), 32'd0);
    chk("rst_cycles", stall_cycles, 32'd0);
    chk("rst_wdog", 32'(wdog_trip), 32'd0);

    rst = 1'b0;
    clear_in();
    #1;
    chk("idle_stall", 32'(pif.stall), 32'h0);
    tick();

    // load-use stall for 3 cycles
    pif.stallreq_id = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("id_stall", 32'(pif.stall), 32'h07);
      chk("id_flush", 32'(pif.flush), 32'h0);
      tick();
    end
    chk("id_cycles", stall_cycles, 32'd3);
    clear_in();

    pif.stallreq_ex = 1'b1;
    pif.stallreq_if = 1'b1;
    #1;
    chk("ex_if_stall", 32'(pif.stall), 32'h0F);
    tick();
    pif.stallreq_mem = 1'b1;
    #1;
    chk("mem_stall", 32'(pif.stall), 32'h1F);
    tick();
    chk("prio_cycles", stall_cycles, 32'd5);
    clear_in();

    // exception with no bus access: immediate flush
    pif.excp_valid = 1'b1;
    pif.excp_type  = 32'h4;
    pif.cp0_epc    = 32'h12345678;
    #1;
    chk("exc_flush", 32'(pif.flush), 32'h1);
    chk("exc_newpc", pif.new_pc, EXC);
    chk("exc_stall", 32'(pif.stall), 32'h0);
    tick();
    chk("exc_state", 32'(ctrl_state), 32'd2);
    chk("exc_cycles", stall_cycles, 32'd5);
    pif.stallreq_id = 1'b1;
    #1;
    chk("recover_flush", 32'(pif.flush), 32'h0);
    chk("recover_stall", 32'(pif.stall), 32'h07);
    tick();
    chk("recover_exit", 32'(ctrl_state), 32'd0);
    chk("recover_cycles", stall_cycles, 32'd6);
    clear_in();

    // ERET deferred behind a 4-cycle bus access, EPC changes afterwards
    pif.excp_valid   = 1'b1;
    pif.excp_type    = 32'hE;
    pif.cp0_epc      = 32'h80001234;
    pif.stallreq_mem = 1'b1;
    #1;
    chk("pend_entry_stall", 32'(pif.stall), 32'h1F);
    chk("pend_entry_flush", 32'(pif.flush), 32'h0);
    tick();
    chk("pend_state", 32'(ctrl_state), 32'd1);
    pif.excp_valid = 1'b0;
    pif.excp_type  = 32'h4;
    pif.cp0_epc    = 32'hDEADBEEF;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("pend_stall", 32'(pif.stall), 32'h1F);
      chk("pend_flush", 32'(pif.flush), 32'h0);
      tick();
    end
    pif.stallreq_mem = 1'b0;
    #1;
    chk("pend_exit_flush", 32'(pif.flush), 32'h1);
    chk("pend_exit_newpc", pif.new_pc, 32'h80001234);
    chk("pend_exit_stall", 32'(pif.stall), 32'h0);
    tick();
    chk("pend_recover", 32'(ctrl_state), 32'd2);
    chk("pend_cycles", stall_cycles, 32'd10);
    tick();
    chk("pend_idle", 32'(ctrl_state), 32'd0);

    // ERET with no bus access redirects to live EPC
    pif.excp_valid = 1'b1;
    pif.excp_type  = 32'hE;
    pif.cp0_epc    = 32'h80000100;
    #1;
    chk("eret_flush", 32'(pif.flush), 32'h1);
    chk("eret_newpc", pif.new_pc, 32'h80000100);
    tick();
    clear_in();
    tick();
    chk("eret_idle", 32'(ctrl_state), 32'd0);

    // reset while pending drops the exception
    pif.excp_valid   = 1'b1;
    pif.excp_type    = 32'h4;
    pif.stallreq_mem = 1'b1;
    tick();
    chk("rpend_state", 32'(ctrl_state), 32'd1);
    chk("rpend_cycles", stall_cycles, 32'd11);
    pif.excp_valid = 1'b0;
    rst = 1'b1;
    #1;
    chk("rpend_flush", 32'(pif.flush), 32'h0);
    chk("rpend_stall", 32'(pif.stall), 32'h0);
    tick();
    chk("rpend_rst_state", 32'(ctrl_state), 32'd0);
    chk("rpend_rst_cycles", stall_cycles, 32'd0);
    rst = 1'b0;
    pif.stallreq_mem = 1'b0;
    #1;
    chk("rpend_dropped", 32'(pif.flush), 32'h0);
    tick();
    chk("rpend_idle", 32'(ctrl_state), 32'd0);

    // watchdog: hold ex stall, look for a forced flush within a bounded window
    pif.stallreq_ex = 1'b1;
    found_at = -1;
    for (int i = 0; i < 40; i++) begin
      #1;
      if (pif.flush === 1'b1 && found_at < 0) begin
        found_at = i;
        chk("wdog_newpc", pif.new_pc, EXC);
        chk("wdog_stall", 32'(pif.stall), 32'h0);
      end
      tick();
    end
`ifdef STALL_WATCHDOG_EN
    chk("wdog_flush_cycle", 32'(found_at), 32'd8);
    chk("wdog_trip", 32'(wdog_trip), 32'd1);
    clear_in();
    tick(); tick();
    chk("wdog_sticky", 32'(wdog_trip), 32'd1);
`else
    chk("wdog_no_flush", 32'(found_at), 32'hFFFFFFFF);
    chk("wdog_off", 32'(wdog_trip), 32'd0);
    chk("wdog_off_cycles", stall_cycles, 32'd40);
    clear_in();
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
